// File: rtl/rr_sel_scheduler_pkg.sv
// ============================================================================
// Module : rr_sel_pkg
// Brief  : Shared constants and types for the round-robin mux-select scheduler
// Rev    : 1.0
// ============================================================================
`default_nettype none

package rr_sel_pkg;

    localparam int c_NUM_CH    = 6;
    localparam int c_SEL_W     = 3;
    localparam int c_MAX_BURST = 4;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } sched_state_t;

    typedef logic [c_SEL_W-1:0] sel_t;

endpackage

`default_nettype wire

// File: rtl/rr_sel_scheduler_if.sv
// ============================================================================
// Module : rr_sel_scheduler_if
// Brief  : Request / select handshake bundle between scheduler and mux side
// Rev    : 1.0
// ============================================================================
`default_nettype none

interface rr_sel_scheduler_if
    import rr_sel_pkg::*;
#(
    parameter int NUM_CH = c_NUM_CH,
    parameter int SEL_W  = c_SEL_W
);

    logic [NUM_CH-1:0] req;
    logic              out_ready;
    logic              out_valid;
    logic [SEL_W-1:0]  sel;
    logic [NUM_CH-1:0] grant;
    logic              out_last;

    modport master (
        input  req,
        input  out_ready,
        output out_valid,
        output sel,
        output grant,
        output out_last
    );

    modport slave (
        output req,
        output out_ready,
        input  out_valid,
        input  sel,
        input  grant,
        input  out_last
    );

endinterface

`default_nettype wire

// File: rtl/rr_sel_scheduler_pick.sv
// ============================================================================
// Module : rr_pick
// Brief  : Combinational rotate-priority encoder, first set req at or after ptr
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_pick
    import rr_sel_pkg::*;
#(
    parameter int NUM_CH = c_NUM_CH,
    parameter int SEL_W  = c_SEL_W
) (
    input  logic [NUM_CH-1:0] req,
    input  logic [SEL_W-1:0]  ptr,
    output logic              found,
    output logic [SEL_W-1:0]  idx
);

    localparam int EXT_W = 1 << SEL_W;

    logic [EXT_W-1:0] w_req_ext;
    logic [SEL_W:0]   w_cand;

    // Scan from farthest offset to nearest so the nearest hit overwrites.
    always_comb begin
        w_req_ext               = '0;
        w_req_ext[NUM_CH-1:0]   = req;
        found                   = 1'b0;
        idx                     = '0;
        w_cand                  = '0;
        for (int k = NUM_CH - 1; k >= 0; k--) begin
            w_cand = {1'b0, ptr} + (SEL_W+1)'(k);
            if (w_cand >= (SEL_W+1)'(NUM_CH)) begin
                w_cand = w_cand - (SEL_W+1)'(NUM_CH);
            end
            if (w_req_ext[w_cand[SEL_W-1:0]]) begin
                found = 1'b1;
                idx   = w_cand[SEL_W-1:0];
            end
        end
    end

endmodule

`default_nettype wire

// File: rtl/rr_sel_scheduler.sv
// ============================================================================
// Module : rr_sel_scheduler
// Brief  : Round-robin burst scheduler driving the select of a six-input mux
// Rev    : 1.0
// ============================================================================
`default_nettype none

module rr_sel_scheduler
    import rr_sel_pkg::*;
#(
    parameter int NUM_CH    = c_NUM_CH,
    parameter int SEL_W     = c_SEL_W,
    parameter int MAX_BURST = c_MAX_BURST
) (
    input  logic                clk,
    input  logic                reset,
    rr_sel_scheduler_if.master  bus
);

    localparam int CNT_W = $clog2(MAX_BURST + 1);
    localparam int EXT_W = 1 << SEL_W;

    sched_state_t      r_state;
    logic [SEL_W-1:0]  r_ptr;
    logic [SEL_W-1:0]  r_sel;
    logic [CNT_W-1:0]  r_beat_cnt;
    logic [NUM_CH-1:0] r_grant;

    logic              w_found;
    logic [SEL_W-1:0]  w_idx;
    logic [EXT_W-1:0]  w_req_ext;
    logic              w_req_sel;
    logic              w_valid;
    logic              w_at_max;
    logic              w_accept;
    logic              w_end;
    logic [SEL_W-1:0]  w_ptr_next;

    rr_pick #(
        .NUM_CH (NUM_CH),
        .SEL_W  (SEL_W)
    ) u_pick (
        .req    (bus.req),
        .ptr    (r_ptr),
        .found  (w_found),
        .idx    (w_idx)
    );

    // Zero-extended so req[sel] is well defined for every sel encoding.
    always_comb begin
        w_req_ext             = '0;
        w_req_ext[NUM_CH-1:0] = bus.req;
    end

    assign w_req_sel  = w_req_ext[r_sel];
    assign w_valid    = (r_state == GRANT) && w_req_sel;
    assign w_at_max   = (r_beat_cnt == CNT_W'(MAX_BURST - 1));
    assign w_accept   = w_valid && bus.out_ready;
    assign w_end      = (r_state == GRANT) && (!w_req_sel || (w_accept && w_at_max));
    assign w_ptr_next = (r_sel == SEL_W'(NUM_CH - 1)) ? '0 : r_sel + 1'b1;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_ptr      <= '0;
            r_sel      <= '0;
            r_beat_cnt <= '0;
            r_grant    <= '0;
        end else begin
            case (r_state)
                IDLE: begin
                    if (w_found) begin
                        r_sel      <= w_idx;
                        r_grant    <= NUM_CH'(1) << w_idx;
                        r_beat_cnt <= '0;
                        r_state    <= GRANT;
                    end
                end
                GRANT: begin
                    // sel is deliberately kept on grant end; only grant clears.
                    if (w_end) begin
                        r_ptr   <= w_ptr_next;
                        r_grant <= '0;
                        r_state <= IDLE;
                    end else if (w_accept) begin
                        r_beat_cnt <= r_beat_cnt + 1'b1;
                    end
                end
                default: r_state <= IDLE;
            endcase
        end
    end

    assign bus.out_valid = w_valid;
    assign bus.sel       = r_sel;
    assign bus.grant     = r_grant;
    assign bus.out_last  = w_valid && w_at_max;

endmodule

`default_nettype wire

// File: doc/rr_sel_scheduler.md
# rr_sel_scheduler

Round-robin scheduler that drives the 3-bit `sel` of the six-input 4-bit output mux. It arbitrates among six channel requests, holds a grant for a bounded burst of beats, and presents the chosen index with a valid/ready handshake. The block sits directly upstream of the mux. It guarantees `sel` never carries an index outside 0..NUM_CH-1, so the mux default (zero output) is never selected during a grant.

## Interface
- `NUM_CH`, 6: number of requesting channels. Legal range is 2..8.
- `SEL_W`, 3: width of `sel`. Must satisfy `2**SEL_W >= NUM_CH`.
- `MAX_BURST`, 4: maximum accepted beats per grant. Legal range is 1..15.
- `clk`  in  1  sole clock; all state updates on its rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `req`  in  NUM_CH  per-channel request, level-sensitive.
- `out_ready`  in  1  downstream accepts the current beat.
- `out_valid`  out  1  `sel` is valid for a beat.
- `sel`  out  SEL_W  granted channel index; feeds the mux select.
- `grant`  out  NUM_CH  one-hot copy of `sel`; all zero when no grant is held.
- `out_last`  out  1  final beat of a count-terminated burst.

## Operation
- Two-state FSM: IDLE and GRANT.
- Internal registers:
  - `ptr`: next-priority channel, 0..NUM_CH-1.
  - `beat_cnt`: accepted beats in the current grant, 0..MAX_BURST-1.
- IDLE behaviour:
  - If any `req` bit is set, pick the first set bit scanning `ptr`, `ptr+1`, … with wrap NUM_CH-1 → 0.
  - Register the pick into `sel` and `grant`, clear `beat_cnt`, and go to GRANT.
  - If no `req` bit is set, remain in IDLE.
- GRANT outputs:
  - `out_valid = req[sel]`, combinational from the registered `sel`.
  - `out_last = out_valid && beat_cnt == MAX_BURST-1`.
- A beat is accepted when `out_valid && out_ready`; an accepted beat increments `beat_cnt`.
- A grant ends when either of these holds in a cycle:
  - an accepted beat with `beat_cnt == MAX_BURST-1`, or
  - `req[sel] == 0`.
- On grant end:
  - `ptr <= (sel == NUM_CH-1) ? 0 : sel+1`.
  - `grant <= 0`.
  - `sel` holds its last value.
  - Go to IDLE.
- `ptr` updates only on grant end. A granted channel therefore gets lowest priority on the next arbitration.
- If `out_ready` is low, `sel` is held stable and `beat_cnt` does not advance.
- Changes on `req` bits other than `req[sel]` have no effect during GRANT.
- Arithmetic rules:
  - `ptr` increment wraps modulo NUM_CH, never modulo `2**SEL_W`.
  - `beat_cnt` width is `$clog2(MAX_BURST+1)`.
  - `sel` is loaded only from the picker, so it never exceeds NUM_CH-1.

## Timing
- Reset values (`reset` high at a clock edge):
  - state = IDLE, `ptr` = 0, `beat_cnt` = 0, `sel` = 0, `grant` = 0.
  - Therefore `out_valid` = 0 and `out_last` = 0.
- Reset has priority over all other inputs, including a mid-burst handshake. The burst is dropped with no `ptr` update beyond the reset value.
- Latency: `req` rises in IDLE at cycle N → `grant`/`sel` registered at edge N+1 → `out_valid` high in cycle N+1.
- Every grant end is followed by exactly one IDLE cycle (a one-cycle bubble) before the next grant.
- Maximum grant length with continuous `out_ready` is MAX_BURST cycles. Throughput per channel is MAX_BURST beats per MAX_BURST+1 cycles.
- `req[sel]` falling while `out_ready` is high: no beat is accepted that cycle, and the grant ends.
- Single requester held high: the same channel is re-granted after each bubble (`ptr` wraps back to it).

## Structure
- Package `rr_sel_pkg` holds:
  - `NUM_CH`, `SEL_W` and `MAX_BURST` default constants;
  - the `sched_state_t` enum (IDLE, GRANT);
  - a `sel_t` typedef of SEL_W bits.
- Sub-module `rr_pick`: a purely combinational rotate-priority encoder.
  - Inputs: `req`, `ptr`.
  - Outputs: `found`, `idx`.
- Top level: FSM, `ptr` and `beat_cnt` registers, output logic.

## Test plan
- Reset mid-burst: grant to ch2, accept 2 beats, assert `reset` → next cycle `out_valid`=0, `grant`=0, `sel`=0. Then `req`=6'b000100 gives ch2 granted 1 cycle later.
- Full rotation: `req`=6'b111111, `out_ready`=1, MAX_BURST=4 → grants ch0,1,2,3,4,5,0 in order. Each grant has 4 beats, `out_last` on the 4th, then a 1-cycle bubble.
- Wrap priority: `ptr`=5 with `req`=6'b100001 → ch5 is granted. Next arbitration grants ch0, and `sel` never shows 6 or 7.
- Backpressure: grant ch3, `out_ready` low for 5 cycles → `sel`=3 held and `beat_cnt` frozen. Raise `out_ready` → exactly 4 beats are accepted.
- Early release: grant ch1, drop `req[1]` after 2 accepted beats → `grant`=0 next cycle, `out_last` never asserted, next pick starts at ch2.
- Single requester: only `req[4]` high → ch4 re-granted after each 1-cycle bubble, and `out_valid` duty is 4/5.
